montgomery_mul: RTL

- Radix-2 bit-serial Montgomery multiplier for the RSA datapath: computes result = A·B·2^-512 mod M for a 512-bit odd modulus.
- Sits directly upstream of the multi-precision adder. It owns one `adder` instance and sequences every addition and subtraction through the adder's start/done handshake.
- Downstream consumer is the modular exponentiation controller.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/adder.sv | 29 ++
 rtl/mont_sel.sv | 40 ++++
 rtl/montgomery_mul.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and encodings for the RSA datapath blocks.
package rsa_pkg;

    localparam int N     = 512;
    localparam int ADD_W = 513;
    localparam int RES_W = 514;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_ISSUE,
        S_PRE_WAIT,
        S_LOOP,
        S_ADD_ISSUE,
        S_ADD_WAIT,
        S_NEXT,
        S_FIN_ISSUE,
        S_FIN_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_B    = 2'd1,
        SEL_M    = 2'd2,
        SEL_BM   = 2'd3
    } sel_t;

endpackage

// File: rtl/adder.sv
// 513-bit add/subtract unit with a start/done handshake and one-cycle latency.
module adder
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [ADD_W-1:0] in_a,
    input  logic [ADD_W-1:0] in_b,
    input  logic             subtract,
    output logic [RES_W-1:0] result,
    output logic             done
);

    // A negative difference shows up as bit RES_W-1 set (two's complement).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                result <= subtract ? ({1'b0, in_a} - {1'b0, in_b})
                                   : ({1'b0, in_a} + {1'b0, in_b});
            end
        end
    end

endmodule

// File: rtl/mont_sel.sv
// Quotient bit and addend selection for one radix-2 Montgomery iteration.
module mont_sel
    import rsa_pkg::*;
(
    input  logic             a_bit,
    input  logic             c_bit,
    input  logic [ADD_W-1:0] b_reg,
    input  logic [ADD_W-1:0] m_reg,
    input  logic [ADD_W-1:0] bm_reg,
    output sel_t             sel,
    output logic [ADD_W-1:0] addend
);

    logic q;

    always_comb begin
        q      = c_bit ^ (a_bit & b_reg[0]);
        sel    = SEL_ZERO;
        addend = '0;
        case ({q, a_bit})
            2'b01: begin
                sel    = SEL_B;
                addend = b_reg;
            end
            2'b10: begin
                sel    = SEL_M;
                addend = m_reg;
            end
            2'b11: begin
                sel    = SEL_BM;
                addend = bm_reg;
            end
            default: begin
                sel    = SEL_ZERO;
                addend = '0;
            end
        endcase
    end

endmodule

// File: rtl/montgomery_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-N mod M.
module montgomery_mul
    import rsa_pkg::*;
#(
    parameter int N         = 512,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

    state_t             state, state_nxt;
    logic [N-1:0]       a_reg;
    logic [ADD_W-1:0]   b_reg, m_reg, bm_reg, c_reg;
    logic [9:0]         iter;
    sel_t               sel;
    logic [ADD_W-1:0]   addend;
    logic               add_start, add_sub, add_done;
    logic [ADD_W-1:0]   add_a, add_b;
    logic [RES_W-1:0]   add_result;
    logic               skip_now;

    mont_sel u_sel (
        .a_bit  (a_reg[0]),
        .c_bit  (c_reg[0]),
        .b_reg  (b_reg),
        .m_reg  (m_reg),
        .bm_reg (bm_reg),
        .sel    (sel),
        .addend (addend)
    );

    adder u_adder (
        .clk      (clk),
        .resetn   (~reset),
        .start    (add_start),
        .in_a     (add_a),
        .in_b     (add_b),
        .subtract (add_sub),
        .result   (add_result),
        .done     (add_done)
    );

    assign skip_now = SKIP_ZERO && (sel == SEL_ZERO);
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every adder request is a one-cycle issue followed by a wait on done.
    always_comb begin
        state_nxt = state;
        add_start = 1'b0;
        add_sub   = 1'b0;
        add_a     = c_reg;
        add_b     = addend;
        case (state)
            S_IDLE:      if (start) state_nxt = S_PRE_ISSUE;
            S_PRE_ISSUE: begin
                add_start = 1'b1;
                add_a     = b_reg;
                add_b     = m_reg;
                state_nxt = S_PRE_WAIT;
            end
            S_PRE_WAIT:  if (add_done) state_nxt = S_LOOP;
            S_LOOP:      state_nxt = skip_now ? S_NEXT : S_ADD_ISSUE;
            S_ADD_ISSUE: begin
                add_start = 1'b1;
                state_nxt = S_ADD_WAIT;
            end
            S_ADD_WAIT:  if (add_done) state_nxt = S_NEXT;
            S_NEXT:      state_nxt = (iter == 10'(N - 1)) ? S_FIN_ISSUE : S_LOOP;
            S_FIN_ISSUE: begin
                add_start = 1'b1;
                add_sub   = 1'b1;
                add_b     = m_reg;
                state_nxt = S_FIN_WAIT;
            end
            S_FIN_WAIT:  if (add_done) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            bm_reg <= '0;
            c_reg  <= '0;
            iter   <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        b_reg <= {1'b0, in_b};
                        m_reg <= {1'b0, in_m};
                        c_reg <= '0;
                        iter  <= '0;
                    end
                end
                S_PRE_WAIT: if (add_done) bm_reg <= add_result[ADD_W-1:0];
                S_LOOP:     if (skip_now) c_reg <= c_reg >> 1;
                S_ADD_WAIT: if (add_done) c_reg <= add_result[RES_W-1:1];
                S_NEXT: begin
                    a_reg <= a_reg >> 1;
                    iter  <= iter + 10'd1;
                end
                // C < 2M, so a single conditional subtraction brings it below M.
                S_FIN_WAIT: begin
                    if (add_done) begin
                        result <= add_result[RES_W-1] ? c_reg[N-1:0] : add_result[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
